sap1_output_display: RTL and testbench

Downstream consumer of the SAP-1 output register. It captures each new 8-bit output value and converts it to three BCD digits with a sequential double-dabble engine. It then drives a time-multiplexed 3-digit 7-segment display with leading-zero blanking, letting the OUT instruction result be read on the board's display pins.

---
 rtl/sap1_disp_pkg.sv | 41 ++++
 rtl/sap1_bin2bcd_seq.sv | 118 +++++++++++
 rtl/sap1_output_display.sv | 130 +++++++++++++
 tb/tb_sap1_output_display.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/sap1_disp_pkg.sv
// -----------------------------------------------------------------------------
// sap1_disp_pkg
// Shared definitions for the SAP-1 output display block:
//   - conv_state_t : states of the sequential binary-to-BCD converter
//   - DIGITS       : number of display digits (ones, tens, hundreds)
//   - SEG_BLANK    : segment pattern for an unlit digit ({g,f,e,d,c,b,a})
//   - seg_lookup() : BCD nibble to 7-segment pattern, active high
// -----------------------------------------------------------------------------
package sap1_disp_pkg;

  localparam int DIGITS = 3;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } conv_state_t;

  // Segment order is {g,f,e,d,c,b,a}. Codes above 9 cannot come out of the
  // converter; they decode to an unlit digit rather than garbage.
  function automatic logic [6:0] seg_lookup(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'd0:    seg = 7'b0111111;
      4'd1:    seg = 7'b0000110;
      4'd2:    seg = 7'b1011011;
      4'd3:    seg = 7'b1001111;
      4'd4:    seg = 7'b1100110;
      4'd5:    seg = 7'b1101101;
      4'd6:    seg = 7'b1111101;
      4'd7:    seg = 7'b0000111;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1101111;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/sap1_bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// sap1_bin2bcd_seq
// Sequential double-dabble converter: 8-bit unsigned value to 3 BCD digits.
// One load edge, eight shift edges, one commit edge (bcd updates 9 edges after
// the load). A load arriving while busy is parked in a one-deep pending slot
// (last one wins) and started straight from the commit edge.
//
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   i_load      in   one-cycle load strobe
//   i_value[8]  in   value to convert
//   o_bcd[12]   out  committed result {hundreds,tens,ones}
//   o_busy      out  conversion in progress (any state other than IDLE)
// -----------------------------------------------------------------------------
module sap1_bin2bcd_seq
  import sap1_disp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic [7:0]  i_value,
  output logic [11:0] o_bcd,
  output logic        o_busy
);

  conv_state_t r_state;
  logic [7:0]  r_shift;
  logic [11:0] r_scratch;
  logic [2:0]  r_iter;
  logic [11:0] r_bcd;
  logic        r_pending;
  logic [7:0]  r_pending_val;

  logic [11:0] w_adj;
  logic [19:0] w_cat_shl;

  // Add-3 correction on every scratch nibble that would reach 10+ after the
  // following doubling.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign w_adj[gi*4 +: 4] = (r_scratch[gi*4 +: 4] >= 4'd5)
                              ? (r_scratch[gi*4 +: 4] + 4'd3)
                              : r_scratch[gi*4 +: 4];
    end
  endgenerate

  assign w_cat_shl = {w_adj[10:0], r_shift, 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_shift       <= 8'd0;
      r_scratch     <= 12'd0;
      r_iter        <= 3'd0;
      r_bcd         <= 12'd0;
      r_pending     <= 1'b0;
      r_pending_val <= 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_load) begin
            r_shift   <= i_value;
            r_scratch <= 12'd0;
            r_iter    <= 3'd0;
            r_state   <= CONV;
          end
        end

        CONV: begin
          r_scratch <= w_cat_shl[19:8];
          r_shift   <= w_cat_shl[7:0];
          r_iter    <= r_iter + 3'd1;
          if (r_iter == 3'd7) begin
            r_state <= COMMIT;
          end
          if (i_load) begin
            r_pending     <= 1'b1;
            r_pending_val <= i_value;
          end
        end

        COMMIT: begin
          r_bcd <= r_scratch;
          if (r_pending) begin
            // Start the parked value; a load on this same edge becomes the
            // next parked value.
            r_shift   <= r_pending_val;
            r_scratch <= 12'd0;
            r_iter    <= 3'd0;
            r_state   <= CONV;
            r_pending <= i_load;
            if (i_load) begin
              r_pending_val <= i_value;
            end
          end else if (i_load) begin
            // A load on the commit edge is pending and consumed at once.
            r_shift   <= i_value;
            r_scratch <= 12'd0;
            r_iter    <= 3'd0;
            r_state   <= CONV;
          end else begin
            r_state <= IDLE;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_bcd  = r_bcd;
  assign o_busy = (r_state != IDLE);

endmodule

// File: rtl/sap1_output_display.sv
// -----------------------------------------------------------------------------
// sap1_output_display
// Captures SAP-1 OUT register values, converts them to BCD and drives a
// time-multiplexed 3-digit 7-segment display with leading-zero blanking.
//
// Parameters:
//   REFRESH_DIV     clk cycles per digit slot (>= 2)
//   SEG_ACTIVE_LOW  1 = invert seg and digit_en (common-anode board)
//
// Ports:
//   clk            in   system clock
//   rst_n          in   asynchronous active-low reset
//   ena            in   display enable; low blanks display and freezes scan
//   out_value[8]   in   output register contents
//   out_load       in   one-cycle strobe when out_value changes
//   seg[7]         out  segments {g,f,e,d,c,b,a}
//   digit_en[3]    out  one-hot digit select [0]=ones [1]=tens [2]=hundreds
//   bcd[12]        out  committed BCD {hundreds,tens,ones}
//   busy           out  conversion in progress
// -----------------------------------------------------------------------------
module sap1_output_display
  import sap1_disp_pkg::*;
#(
  parameter int REFRESH_DIV    = 10_000,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic [7:0]  out_value,
  input  logic        out_load,
  output logic [6:0]  seg,
  output logic [2:0]  digit_en,
  output logic [11:0] bcd,
  output logic        busy
);

  localparam int              CNT_W   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] r_scan_cnt;
  logic [1:0]       r_digit_idx;

  logic [11:0]       w_bcd;
  logic [DIGITS-1:0] w_show;
  logic [DIGITS-1:0] w_en_raw;
  logic [3:0]        w_nib;
  logic              w_nib_show;
  logic [6:0]        w_seg_raw;
  logic [6:0]        w_seg_gated;
  logic [2:0]        w_en_gated;

  sap1_bin2bcd_seq u_bin2bcd (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (out_load),
    .i_value (out_value),
    .o_bcd   (w_bcd),
    .o_busy  (busy)
  );

  assign bcd = w_bcd;

  // Slot timer and digit index; both hold while the display is disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_cnt  <= '0;
      r_digit_idx <= 2'd0;
    end else if (ena) begin
      if (r_scan_cnt == CNT_MAX) begin
        r_scan_cnt  <= '0;
        r_digit_idx <= (r_digit_idx == 2'd2) ? 2'd0 : (r_digit_idx + 2'd1);
      end else begin
        r_scan_cnt <= r_scan_cnt + 1'b1;
      end
    end
  end

  // Leading-zero blanking from the committed value: a higher digit is shown
  // only when it or something above it is non-zero. Ones is always shown.
  assign w_show[0] = 1'b1;
  assign w_show[1] = (w_bcd[11:8] != 4'd0) || (w_bcd[7:4] != 4'd0);
  assign w_show[2] = (w_bcd[11:8] != 4'd0);

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_en
      assign w_en_raw[gi] = (r_digit_idx == 2'(gi));
    end
  endgenerate

  always_comb begin
    w_nib      = 4'd0;
    w_nib_show = 1'b0;
    case (r_digit_idx)
      2'd0: begin
        w_nib      = w_bcd[3:0];
        w_nib_show = w_show[0];
      end
      2'd1: begin
        w_nib      = w_bcd[7:4];
        w_nib_show = w_show[1];
      end
      2'd2: begin
        w_nib      = w_bcd[11:8];
        w_nib_show = w_show[2];
      end
      default: begin
        w_nib      = 4'd0;
        w_nib_show = 1'b0;
      end
    endcase
  end

  assign w_seg_raw   = w_nib_show ? seg_lookup(w_nib) : SEG_BLANK;
  assign w_seg_gated = ena ? w_seg_raw : SEG_BLANK;
  assign w_en_gated  = ena ? w_en_raw : 3'b000;

  // Polarity applies last so blank and disabled states invert too.
  generate
    if (SEG_ACTIVE_LOW) begin : g_pol_low
      assign seg      = ~w_seg_gated;
      assign digit_en = ~w_en_gated;
    end else begin : g_pol_high
      assign seg      = w_seg_gated;
      assign digit_en = w_en_gated;
    end
  endgenerate

endmodule

// File: tb/tb_sap1_output_display.sv
// -----------------------------------------------------------------------------
// tb_sap1_output_display
// Directed bench for sap1_output_display. Two instances share stimulus: one
// active-high, one with SEG_ACTIVE_LOW=1. Both run REFRESH_DIV=4. A small scan
// model (slot counter + index) and a hand-written segment table provide the
// expected display; conversion results are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_sap1_output_display;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b1;
  logic [7:0]  out_value = 8'd0;
  logic        out_load = 1'b0;

  logic [6:0]  seg, seg_al;
  logic [2:0]  digit_en, digit_en_al;
  logic [11:0] bcd, bcd_al;
  logic        busy, busy_al;

  int n_cmp = 0;
  int n_err = 0;

  // Scan model and expected committed value
  int          m_cnt = 0;
  int          m_idx = 0;
  logic [11:0] m_bcd = 12'h000;

  always #5 clk = ~clk;

  sap1_output_display #(.REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b0)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .out_value (out_value),
    .out_load  (out_load),
    .seg       (seg),
    .digit_en  (digit_en),
    .bcd       (bcd),
    .busy      (busy)
  );

  sap1_output_display #(.REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b1)) u_dut_al (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .out_value (out_value),
    .out_load  (out_load),
    .seg       (seg_al),
    .digit_en  (digit_en_al),
    .bcd       (bcd_al),
    .busy      (busy_al)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] f_seg_code(input logic [3:0] d);
    case (d)
      4'd0: return 7'b0111111;
      4'd1: return 7'b0000110;
      4'd2: return 7'b1011011;
      4'd3: return 7'b1001111;
      4'd4: return 7'b1100110;
      4'd5: return 7'b1101101;
      4'd6: return 7'b1111101;
      4'd7: return 7'b0000111;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [6:0] f_exp_seg(input logic [11:0] b, input int idx);
    logic [3:0] h, t, o;
    h = b[11:8];
    t = b[7:4];
    o = b[3:0];
    case (idx)
      0: return f_seg_code(o);
      1: return (h == 4'd0 && t == 4'd0) ? 7'b0000000 : f_seg_code(t);
      2: return (h == 4'd0) ? 7'b0000000 : f_seg_code(h);
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic check_disp();
    logic [2:0] exp_en;
    logic [6:0] exp_seg;
    exp_en  = ena ? (3'b001 << m_idx) : 3'b000;
    exp_seg = ena ? f_exp_seg(m_bcd, m_idx) : 7'b0000000;
    check_val("digit_en", {29'd0, digit_en}, {29'd0, exp_en});
    check_val("seg", {25'd0, seg}, {25'd0, exp_seg});
    check_val("digit_en_al", {29'd0, digit_en_al}, {29'd0, ~exp_en});
    check_val("seg_al", {25'd0, seg_al}, {25'd0, ~exp_seg});
  endtask

  // One clock edge: advance the scan model, then sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    if (!rst_n) begin
      m_cnt = 0;
      m_idx = 0;
    end else if (ena) begin
      if (m_cnt == 3) begin
        m_cnt = 0;
        m_idx = (m_idx + 1) % 3;
      end else begin
        m_cnt++;
      end
    end
    #1;
    check_disp();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Single conversion: load on edge 1, result expected on edge 10.
  task automatic run_conv(input logic [7:0] v, input logic [11:0] exp);
    logic [11:0] old;
    old       = m_bcd;
    out_value = v;
    out_load  = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      if (e == 10) m_bcd = exp;
      step();
      out_load = 1'b0;
      check_val("busy", {31'd0, busy}, (e < 10) ? 32'd1 : 32'd0);
      check_val("bcd", {20'd0, bcd}, {20'd0, (e < 10) ? old : exp});
    end
    $display("conv 0x%02h -> bcd 0x%03h busy %0d", v, bcd, busy);
  endtask

  initial begin
    // Reset state, asynchronous (no clock edge yet)
    #2;
    check_val("rst_bcd", {20'd0, bcd}, 32'h000);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_disp();
    #10;
    rst_n = 1'b1;

    // One full scan of 0: tens/hundreds blank
    idle(12);

    run_conv(8'hFF, 12'h255);
    idle(12);
    run_conv(8'h07, 12'h007);
    idle(12);
    run_conv(8'h64, 12'h100);
    idle(12);

    // Back-to-back loads: 0x2A is overwritten by 0x80 in the pending slot
    begin
      logic [11:0] old;
      old = m_bcd;
      for (int e = 1; e <= 19; e++) begin
        if (e == 1) begin out_value = 8'h0C; out_load = 1'b1; end
        if (e == 3) begin out_value = 8'h2A; out_load = 1'b1; end
        if (e == 5) begin out_value = 8'h80; out_load = 1'b1; end
        if (e == 10) m_bcd = 12'h012;
        if (e == 19) m_bcd = 12'h128;
        step();
        out_load = 1'b0;
        check_val("pend_busy", {31'd0, busy}, (e < 19) ? 32'd1 : 32'd0);
        check_val("pend_bcd", {20'd0, bcd},
                  {20'd0, (e < 10) ? old : ((e < 19) ? 12'h012 : 12'h128)});
      end
      $display("pending seq 0x0C,0x2A,0x80 -> bcd 0x%03h", bcd);
    end
    idle(6);

    // Reset in the middle of converting 0xC8 with 0x33 pending
    out_value = 8'hC8;
    out_load  = 1'b1;
    step();
    out_load = 1'b0;
    step();
    out_value = 8'h33;
    out_load  = 1'b1;
    step();
    out_load = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    m_cnt = 0;
    m_idx = 0;
    m_bcd = 12'h000;
    check_val("midrst_bcd", {20'd0, bcd}, 32'h000);
    check_val("midrst_busy", {31'd0, busy}, 32'd0);
    check_disp();
    idle(2);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      check_val("postrst_bcd", {20'd0, bcd}, 32'h000);
      check_val("postrst_busy", {31'd0, busy}, 32'd0);
    end
    $display("reset during conversion -> bcd 0x%03h busy %0d", bcd, busy);

    // Disable mid-slot, convert 0x58 while disabled, then resume scanning
    idle(2);
    ena = 1'b0;
    run_conv(8'h58, 12'h088);
    ena = 1'b1;
    idle(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
